// File: rtl/nasti_stream_mux_pkg.sv
// nasti_stream_mux_pkg: shared types for the stream mux and its skid buffer.
//   - field widths of a nasti_stream beat
//   - mux FSM state enum
//   - beat_t: one buffered beat (data, strb, keep, last, id, dest, user)
//   - rr_pick: round-robin first-valid scan starting at a pointer
package nasti_stream_mux_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned ID_W     = 4;
    localparam int unsigned DEST_W   = 4;
    localparam int unsigned USER_W   = 4;
    // Upper bound on lanes the arbiter scan function handles.
    localparam int unsigned MAX_PORT = 16;
    localparam int unsigned MAX_SEL  = $clog2(MAX_PORT);

    typedef enum logic {
        StIdle,
        StLocked
    } mux_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic [STRB_W-1:0] keep;
        logic              last;
        logic [ID_W-1:0]   id;
        logic [DEST_W-1:0] dest;
        logic [USER_W-1:0] user;
    } beat_t;

    // Returns the first lane with valid set, scanning ptr, ptr+1, ... mod n.
    // Result is only meaningful when at least one of the n lanes is valid.
    function automatic int unsigned rr_pick(input logic [MAX_PORT-1:0] valid,
                                            input int unsigned         ptr,
                                            input int unsigned         n);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_PORT; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !found && valid[idx[MAX_SEL-1:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/nasti_stream_skid_buf.sv
// nasti_stream_skid_buf: 2-entry FIFO of stream beats.
//   aclk, aresetn   clock, synchronous active-low reset
//   in_valid/in_beat  push side; caller must not push while full
//   full            registered (count == 2), safe to use as an upstream ready
//   out_valid/out_ready/out_beat  pop side, head entry presented
module nasti_stream_skid_buf
    import nasti_stream_mux_pkg::*;
(
    input  logic  aclk,
    input  logic  aresetn,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  full,
    output logic  out_valid,
    input  logic  out_ready,
    output beat_t out_beat
);

    beat_t      mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign full      = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_beat  = mem[rd_ptr];
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; count gates visibility.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= in_beat;
        end
    end

endmodule

// File: rtl/nasti_stream_mux.sv
// nasti_stream_mux: packet-granular round-robin merge of N_PORT stream lanes.
//   aclk, aresetn        clock, synchronous active-low reset
//   master_t_*           N_PORT input lanes (fields + t_valid in, t_ready out)
//   slave_t_*            merged output (fields + t_valid out, t_ready in)
// Output is registered through a 2-entry skid buffer; input ready depends only
// on registered state, never on slave_t_ready.
module nasti_stream_mux
    import nasti_stream_mux_pkg::*;
#(
    parameter int unsigned N_PORT    = 1,
    parameter int unsigned SEL_WIDTH = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [N_PORT-1:0][DATA_W-1:0]  master_t_data,
    input  logic [N_PORT-1:0][STRB_W-1:0]  master_t_strb,
    input  logic [N_PORT-1:0][STRB_W-1:0]  master_t_keep,
    input  logic [N_PORT-1:0]              master_t_last,
    input  logic [N_PORT-1:0][ID_W-1:0]    master_t_id,
    input  logic [N_PORT-1:0][DEST_W-1:0]  master_t_dest,
    input  logic [N_PORT-1:0][USER_W-1:0]  master_t_user,
    input  logic [N_PORT-1:0]              master_t_valid,
    output logic [N_PORT-1:0]              master_t_ready,
    output logic [DATA_W-1:0]              slave_t_data,
    output logic [STRB_W-1:0]              slave_t_strb,
    output logic [STRB_W-1:0]              slave_t_keep,
    output logic                           slave_t_last,
    output logic [ID_W-1:0]                slave_t_id,
    output logic [DEST_W-1:0]              slave_t_dest,
    output logic [USER_W-1:0]              slave_t_user,
    output logic                           slave_t_valid,
    input  logic                           slave_t_ready
);

    mux_state_e            state;
    logic [SEL_WIDTH-1:0]  grant;
    logic [SEL_WIDTH-1:0]  rr_ptr;
    logic [SEL_WIDTH-1:0]  winner;
    logic [SEL_WIDTH-1:0]  grant_next;
    logic [MAX_PORT-1:0]   valid_ext;
    logic                  sel_valid;
    beat_t                 sel_beat;
    beat_t                 out_beat;
    logic                  full;
    logic                  accept;

    // Lane select by comparison rather than indexing keeps N_PORT=1 width-clean.
    always_comb begin
        valid_ext      = '0;
        sel_valid      = 1'b0;
        sel_beat       = '0;
        master_t_ready = '0;
        for (int unsigned i = 0; i < N_PORT; i++) begin
            valid_ext[i] = master_t_valid[i];
            if (grant == SEL_WIDTH'(i)) begin
                sel_valid         = master_t_valid[i];
                sel_beat.data     = master_t_data[i];
                sel_beat.strb     = master_t_strb[i];
                sel_beat.keep     = master_t_keep[i];
                sel_beat.last     = master_t_last[i];
                sel_beat.id       = master_t_id[i];
                sel_beat.dest     = master_t_dest[i];
                sel_beat.user     = master_t_user[i];
                master_t_ready[i] = (state == StLocked) && !full;
            end
        end
    end

    assign accept     = sel_valid && (state == StLocked) && !full;
    assign winner     = SEL_WIDTH'(rr_pick(valid_ext, 32'(rr_ptr), N_PORT));
    assign grant_next = (grant == SEL_WIDTH'(N_PORT - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state  <= StIdle;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (|master_t_valid) begin
                        grant <= winner;
                        state <= StLocked;
                    end
                end
                StLocked: begin
                    if (accept && sel_beat.last) begin
                        state  <= StIdle;
                        rr_ptr <= grant_next;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    nasti_stream_skid_buf u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_valid  (accept),
        .in_beat   (sel_beat),
        .full      (full),
        .out_valid (slave_t_valid),
        .out_ready (slave_t_ready),
        .out_beat  (out_beat)
    );

    assign slave_t_data = out_beat.data;
    assign slave_t_strb = out_beat.strb;
    assign slave_t_keep = out_beat.keep;
    assign slave_t_last = out_beat.last;
    assign slave_t_id   = out_beat.id;
    assign slave_t_dest = out_beat.dest;
    assign slave_t_user = out_beat.user;

endmodule

// File: tb/tb_nasti_stream_mux.sv
module tb_nasti_stream_mux;
    import nasti_stream_mux_pkg::*;

    localparam int NP = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    // 4-lane instance
    logic [NP-1:0][DATA_W-1:0] m_data;
    logic [NP-1:0][STRB_W-1:0] m_strb, m_keep;
    logic [NP-1:0]             m_last, m_valid, m_ready;
    logic [NP-1:0][ID_W-1:0]   m_id;
    logic [NP-1:0][DEST_W-1:0] m_dest;
    logic [NP-1:0][USER_W-1:0] m_user;
    logic [DATA_W-1:0]         s_data;
    logic [STRB_W-1:0]         s_strb, s_keep;
    logic                      s_last, s_valid, s_ready;
    logic [ID_W-1:0]           s_id;
    logic [DEST_W-1:0]         s_dest;
    logic [USER_W-1:0]         s_user;

    // 1-lane instance
    logic [0:0][DATA_W-1:0]    m1_data;
    logic [0:0][STRB_W-1:0]    m1_strb, m1_keep;
    logic [0:0]                m1_last, m1_valid, m1_ready;
    logic [0:0][ID_W-1:0]      m1_id;
    logic [0:0][DEST_W-1:0]    m1_dest;
    logic [0:0][USER_W-1:0]    m1_user;
    logic [DATA_W-1:0]         s1_data;
    logic [STRB_W-1:0]         s1_strb, s1_keep;
    logic                      s1_last, s1_valid;
    logic                      s1_ready = 1'b1;
    logic [ID_W-1:0]           s1_id;
    logic [DEST_W-1:0]         s1_dest;
    logic [USER_W-1:0]         s1_user;

    nasti_stream_mux #(.N_PORT(NP)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .master_t_data(m_data), .master_t_strb(m_strb), .master_t_keep(m_keep),
        .master_t_last(m_last), .master_t_id(m_id), .master_t_dest(m_dest),
        .master_t_user(m_user), .master_t_valid(m_valid), .master_t_ready(m_ready),
        .slave_t_data(s_data), .slave_t_strb(s_strb), .slave_t_keep(s_keep),
        .slave_t_last(s_last), .slave_t_id(s_id), .slave_t_dest(s_dest),
        .slave_t_user(s_user), .slave_t_valid(s_valid), .slave_t_ready(s_ready)
    );

    nasti_stream_mux #(.N_PORT(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .master_t_data(m1_data), .master_t_strb(m1_strb), .master_t_keep(m1_keep),
        .master_t_last(m1_last), .master_t_id(m1_id), .master_t_dest(m1_dest),
        .master_t_user(m1_user), .master_t_valid(m1_valid), .master_t_ready(m1_ready),
        .slave_t_data(s1_data), .slave_t_strb(s1_strb), .slave_t_keep(s1_keep),
        .slave_t_last(s1_last), .slave_t_id(s1_id), .slave_t_dest(s1_dest),
        .slave_t_user(s1_user), .slave_t_valid(s1_valid), .slave_t_ready(s1_ready)
    );

    beat_t lane_q [NP][$];
    beat_t q1[$];
    beat_t exp_q[$];
    beat_t exp1_q[$];
    logic  hold [NP];
    logic [NP-1:0] acc;
    logic  acc1;
    int    occ;
    int    cyc;
    int    acc_cyc[$];
    bit    toggle_rdy;
    int    n_checks;
    int    n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic beat_t make_beat(input int lane, input int idx, input bit last);
        beat_t b;
        b.data = {8'(lane), 8'(idx), 16'($urandom)};
        b.strb = 4'($urandom);
        b.keep = 4'($urandom);
        b.last = last;
        b.id   = 4'($urandom);
        b.dest = 4'($urandom);
        b.user = 4'($urandom);
        return b;
    endfunction

    // expect=0 loads beats that are later discarded by reset.
    task automatic load_pkt(input int lane, input int len, input bit expect_out);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b = make_beat(lane, k, k == len - 1);
            lane_q[lane].push_back(b);
            if (expect_out) exp_q.push_back(b);
        end
    endtask

    task automatic load_pkt1(input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b = make_beat(9, k, k == len - 1);
            q1.push_back(b);
            exp1_q.push_back(b);
        end
    endtask

    task automatic refresh_inputs();
        beat_t b;
        for (int i = 0; i < NP; i++) begin
            if (lane_q[i].size() > 0 && !hold[i]) begin
                b = lane_q[i][0];
                m_valid[i] = 1'b1;
                m_data[i] = b.data; m_strb[i] = b.strb; m_keep[i] = b.keep;
                m_last[i] = b.last; m_id[i] = b.id; m_dest[i] = b.dest; m_user[i] = b.user;
            end else begin
                m_valid[i] = 1'b0;
            end
        end
        if (q1.size() > 0) begin
            b = q1[0];
            m1_valid[0] = 1'b1;
            m1_data[0] = b.data; m1_strb[0] = b.strb; m1_keep[0] = b.keep;
            m1_last[0] = b.last; m1_id[0] = b.id; m1_dest[0] = b.dest; m1_user[0] = b.user;
        end else begin
            m1_valid[0] = 1'b0;
        end
    endtask

    // Drivers: retire beats accepted at this edge, then present the next ones.
    always @(posedge aclk) begin
        #1;
        cyc++;
        for (int i = 0; i < NP; i++) begin
            if (acc[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        end
        if (acc1 && q1.size() > 0) void'(q1.pop_front());
        if (toggle_rdy) s_ready = (cyc % 3 == 0);
        refresh_inputs();
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge aclk) begin
        beat_t g;
        beat_t e;
        logic  pop;
        if (!aresetn) begin
            occ  = 0;
            acc  = '0;
            acc1 = 1'b0;
        end else begin
            acc  = m_valid & m_ready;
            acc1 = m1_valid[0] & m1_ready[0];
            pop  = s_valid && s_ready;
            if (occ == 2) check("ready_when_full", 64'(m_ready), 64'(0));
            check("at_most_one_ready", 64'($countones(m_ready) <= 1), 64'(1));
            if (|acc) acc_cyc.push_back(cyc);
            if (pop) begin
                g = '{data: s_data, strb: s_strb, keep: s_keep, last: s_last,
                      id: s_id, dest: s_dest, user: s_user};
                if (exp_q.size() == 0) begin
                    check("unexpected_beat_pending", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(g), 64'(e));
                end
            end
            occ = occ + int'(|acc) - int'(pop);
            if (s1_valid && s1_ready) begin
                g = '{data: s1_data, strb: s1_strb, keep: s1_keep, last: s1_last,
                      id: s1_id, dest: s1_dest, user: s1_user};
                if (exp1_q.size() == 0) begin
                    check("p1_unexpected_beat_pending", 64'(exp1_q.size()), 64'(1));
                end else begin
                    e = exp1_q.pop_front();
                    check("p1_beat", 64'(g), 64'(e));
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            done = (exp_q.size() == 0) && (exp1_q.size() == 0) && (q1.size() == 0);
            for (int i = 0; i < NP; i++) if (lane_q[i].size() != 0) done = 1'b0;
            if (!done) begin
                @(posedge aclk);
                #2;
            end
        end
        check({tag, "_drained"}, 64'(done), 64'(1));
    endtask

    task automatic wait_lane_le(input string tag, input int lane, input int n, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            if (lane_q[lane].size() <= n) done = 1'b1;
            else begin
                @(posedge aclk);
                #2;
            end
        end
        check({tag, "_lane_progress"}, 64'(done), 64'(1));
    endtask

    initial begin
        n_checks = 0; n_errors = 0; occ = 0; cyc = 0;
        acc = '0; acc1 = 1'b0; toggle_rdy = 1'b0; s_ready = 1'b1;
        m_valid = '0; m_data = '0; m_strb = '0; m_keep = '0; m_last = '0;
        m_id = '0; m_dest = '0; m_user = '0;
        m1_valid = '0; m1_data = '0; m1_strb = '0; m1_keep = '0; m1_last = '0;
        m1_id = '0; m1_dest = '0; m1_user = '0;
        for (int i = 0; i < NP; i++) hold[i] = 1'b0;

        repeat (3) @(posedge aclk);
        #2;
        check("reset_slave_valid", 64'(s_valid), 64'(0));
        check("reset_master_ready", 64'(m_ready), 64'(0));
        check("reset_p1_slave_valid", 64'(s1_valid), 64'(0));

        // Lanes 1 and 3 valid at reset release: lane 1 wins, then lane 3.
        load_pkt(1, 3, 1'b1);
        load_pkt(3, 3, 1'b1);
        refresh_inputs();
        aresetn = 1'b1;
        wait_idle("two_lanes", 200);
        check("two_lanes_rr_ptr", 64'(dut.rr_ptr), 64'(0));

        // All lanes offer single-beat packets: order 0,1,2,3,0,1,2,3, one
        // idle cycle between accepts.
        acc_cyc.delete();
        for (int r = 0; r < 2; r++) for (int l = 0; l < NP; l++) load_pkt(l, 1, 1'b1);
        refresh_inputs();
        wait_idle("all_lanes", 200);
        check("all_lanes_accepts", 64'(acc_cyc.size()), 64'(8));
        if (acc_cyc.size() == 8)
            check("all_lanes_accept_span", 64'(acc_cyc[7] - acc_cyc[0]), 64'(14));

        // Lane 2 long packet under output backpressure; lanes 0/1 arrive mid-packet.
        toggle_rdy = 1'b1;
        load_pkt(2, 8, 1'b1);
        refresh_inputs();
        wait_lane_le("backpressure", 2, 7, 50);
        load_pkt(0, 1, 1'b1);
        load_pkt(1, 1, 1'b1);
        refresh_inputs();
        wait_idle("backpressure", 300);
        toggle_rdy = 1'b0;
        s_ready = 1'b1;

        // Lane 0 stalls mid-packet; lane 1 must not be granted meanwhile.
        load_pkt(0, 4, 1'b1);
        load_pkt(1, 1, 1'b1);
        refresh_inputs();
        wait_lane_le("stall", 0, 2, 50);
        hold[0] = 1'b1;
        refresh_inputs();
        repeat (5) begin
            @(posedge aclk);
            #2;
            check("stall_lane1_ready", 64'(m_ready[1]), 64'(0));
            check("stall_lane0_ready", 64'(m_ready[0]), 64'(1));
        end
        hold[0] = 1'b0;
        refresh_inputs();
        wait_idle("stall", 200);

        // Reset with two beats buffered; nothing from that packet may emerge.
        s_ready = 1'b0;
        load_pkt(0, 4, 1'b0);
        refresh_inputs();
        wait_lane_le("mid_reset", 0, 2, 50);
        aresetn = 1'b0;
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        lane_q[0].delete();
        refresh_inputs();
        check("mid_reset_slave_valid", 64'(s_valid), 64'(0));
        check("mid_reset_master_ready", 64'(m_ready), 64'(0));
        s_ready = 1'b1;
        repeat (4) @(posedge aclk);
        #2;
        check("mid_reset_quiet", 64'(s_valid), 64'(0));
        load_pkt(0, 1, 1'b1);
        load_pkt(2, 1, 1'b1);
        refresh_inputs();
        wait_idle("after_reset", 100);

        // Single-lane instance: back-to-back 1- and 5-beat packets.
        load_pkt1(1);
        load_pkt1(5);
        refresh_inputs();
        wait_idle("single_lane", 100);
        check("single_lane_rr_ptr", 64'(dut1.rr_ptr), 64'(0));
        check("single_lane_grant", 64'(dut1.grant), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nasti_stream_mux.md
Name: nasti_stream_mux

Overview:
- Merges N_PORT independent nasti_stream input lanes into one output stream.
- Round-robin arbitration at packet granularity: once a lane is granted, it holds the output until its t_last beat is accepted.
- Sits directly upstream of the stream demux stage, so many producers can share one routed stream path.
- Output passes through a 2-entry skid buffer, so output t_ready never has a combinational path to any input t_ready.

Parameters:
- N_PORT, 1, number of input lanes (>=1).
- SEL_WIDTH, (N_PORT>1 ? $clog2(N_PORT) : 1), width of the grant and round-robin pointer registers.

Ports:
- aclk  input  1  clock; all state updates on rising edge.
- aresetn  input  1  reset, synchronous, active-low.
- master  nasti_stream_channel.slave  N_PORT lanes  input streams: t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user, t_valid per lane; t_ready per lane driven by this block.
- slave  nasti_stream_channel.master  lane 0 only  merged output stream with the same fields; t_ready driven by the consumer.

Behaviour:
- Reset (aresetn=0 sampled at a clock edge):
  - state=IDLE, grant=0, rr_ptr=0, skid count=0.
  - slave.t_valid=0, all master.t_ready=0.
  - Reset mid-packet discards buffered beats and the partial packet; no beat is emitted after reset.
- FSM states: IDLE, LOCKED.
- IDLE:
  - Scan lanes rr_ptr, rr_ptr+1, ..., wrapping mod N_PORT; the first lane with t_valid=1 wins.
  - On the clock edge where any lane is valid: grant<=winner, state<=LOCKED.
  - No beats are accepted in IDLE (arbitration latency 1 cycle).
- LOCKED:
  - master.t_ready[i] = (i==grant) && !full, where full = (skid count==2) from a register.
  - All other lanes see t_ready=0.
  - A beat is accepted when master.t_valid[grant] && master.t_ready[grant]; all fields are written into the skid buffer.
  - On an accepted beat with t_last=1: state<=IDLE, rr_ptr<=(grant+1) mod N_PORT.
- Skid buffer: 2-entry FIFO.
  - Push on input accept, pop on slave.t_valid && slave.t_ready; simultaneous push and pop leaves count unchanged.
  - slave.t_valid = (count!=0); output fields come from the head entry.
  - Input-to-output latency: 1 cycle.
  - Steady-state throughput: 1 beat/cycle within a packet.
- Fields pass through unmodified, including t_dest, t_id and t_user; no reordering and no interleaving between packets.
- Boundary conditions:
  - Output backpressure: count reaches 2 and input ready drops the next cycle; no beat is lost or duplicated.
  - Single-beat packet (t_last on the first beat): returns to IDLE after 1 accept.
  - Upstream t_valid drop mid-packet: stay LOCKED and wait; no rearbitration.
  - A lane deasserting t_valid in IDLE before the grant edge is not required to be supported; upstream must hold t_valid until the beat is accepted.
  - N_PORT=1: grant is always 0 and the round-robin pointer stays 0.
  - Wrap-around: rr_ptr = N_PORT-1 followed by a grant of lane N_PORT-1 gives rr_ptr=0.
- Between packets, the input side incurs 1 IDLE bubble cycle; the skid buffer may hide it at the output.

Decomposition:
- Shared stream package holds:
  - mux FSM state enum {IDLE, LOCKED};
  - a beat struct bundling data, strb, keep, last, id, dest and user, used by the skid buffer.
- Natural sub-module: nasti_stream_skid_buf, the 2-entry skid FIFO of beat structs, reusable elsewhere.
- Arbiter: round-robin priority scan inline as a combinational function in the package.

Test Plan:
- N_PORT=4; lanes 1 and 3 valid at reset release with 3-beat packets, slave.t_ready=1 → output: lane 1 packet (3 beats), then lane 3 packet; rr_ptr=0 afterwards.
- All 4 lanes continuously offer 1-beat packets → grant order 0,1,2,3,0,1 with no starvation; 1 bubble per packet on the input side.
- Lane 2 sends an 8-beat packet while slave.t_ready toggles 1,0,0,1,... → all 8 beats exactly once, in order; master.t_ready[2] low within 1 cycle of count==2; no other lane is granted before t_last.
- Lane 0 mid-packet drops t_valid for 5 cycles while lane 1 is valid → lane 1 is not granted until lane 0's t_last is accepted.
- aresetn asserted for 1 cycle after the 2nd beat of a 4-beat packet, with 2 beats buffered → slave.t_valid=0 and all t_ready=0 the cycle after; buffered beats are never emitted; arbitration restarts at lane 0.
- N_PORT=1; back-to-back packets of 1 and 5 beats → correct pass-through, t_dest/t_id/t_user preserved bit-exactly.
